// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } dump_state_t;

  typedef logic [AW_DEF-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready beat stream carrying {address, data} pairs out of the dumper.
interface regfile_dumper_if
  import regfile_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: IDLE/FETCH/SEND/FIN state machine and register index counter.
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          out_ready,
  output logic [AW-1:0] ra,
  output logic          load,
  output logic          accept,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] FirstIdx = AW'(FIRST_REG);
  localparam logic [AW-1:0] LastIdx  = AW'(LAST_REG);

  dump_state_t   state_q;
  logic [AW-1:0] idx_q;

  // State and index advance; idx stops at LAST_REG so it never wraps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= FirstIdx;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            idx_q   <= FirstIdx;
          end
        end
        FETCH: state_q <= SEND;
        SEND: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          idx_q   <= FirstIdx;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ra     = idx_q;
  assign load   = (state_q == FETCH);
  assign accept = (state_q == SEND) && out_ready;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);

endmodule

// File: rtl/regfile_dumper.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through one async read
// port and streams {addr, data} beats on a valid/ready interface.
// Optional running checksum enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ra,
  input  logic [DW-1:0]    rd,
  regfile_dumper_if.master dump
`ifdef REGFILE_DUMP_CHECKSUM_EN
  ,
  output logic [DW-1:0]    csum,
  output logic             csum_valid
`endif
);

  logic          load;
  logic          accept;
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_data_q;

  regfile_dump_ctrl #(
    .AW        (AW),
    .FIRST_REG (FIRST_REG),
    .LAST_REG  (LAST_REG)
  ) u_ctrl (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .out_ready (dump.out_ready),
    .ra        (ra),
    .load      (load),
    .accept    (accept),
    .busy      (busy),
    .done      (done)
  );

  // Output holding register: captured in FETCH, held until the handshake.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= ra;
      out_data_q  <= rd;
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  assign dump.out_valid = out_valid_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_data  = out_data_q;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DW-1:0] csum_q;
  logic          csum_valid_q;
  logic          last_accept;

  assign last_accept = accept && (ra == AW'(LAST_REG));

  // Rotate-xor accumulator; valid is raised on the last beat so it covers FIN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else if (start && !busy) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else if (accept) begin
      csum_q <= {csum_q[DW-2:0], csum_q[DW-1]} ^ out_data_q;
      if (last_accept) begin
        csum_valid_q <= 1'b1;
      end
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench for regfile_dumper; the bench plays the register file.
module tb_regfile_dumper;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [31:0] mem [32];

  regfile_dumper_if #(.AW(5), .DW(32)) dif ();

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] csum, csum2;
  logic        csum_valid, csum_valid2;
  logic        start2 = 1'b0;
  logic        busy2, done2;
  logic [4:0]  ra2;
  logic [31:0] rd2;
  regfile_dumper_if #(.AW(5), .DW(32)) dif2 ();
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : mem[ra2];
`endif

  assign rd = (ra == 5'd0) ? 32'h0 : mem[ra];

  regfile_dumper #(.AW(5), .DW(32), .FIRST_REG(0), .LAST_REG(31)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ra         (ra),
    .rd         (rd),
    .dump       (dif)
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    .csum       (csum),
    .csum_valid (csum_valid)
`endif
  );

`ifdef REGFILE_DUMP_CHECKSUM_EN
  regfile_dumper #(.AW(5), .DW(32), .FIRST_REG(1), .LAST_REG(3)) dut2 (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start2),
    .busy       (busy2),
    .done       (done2),
    .ra         (ra2),
    .rd         (rd2),
    .dump       (dif2),
    .csum       (csum2),
    .csum_valid (csum_valid2)
  );
`endif

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  // Beat collector and hold-while-stalled checker.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;
  beat_t       got_q[$];
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_a;
  logic [31:0] prev_d;

  always @(negedge clock) begin
    if (prev_stall) begin
      check("stall_valid", 64'(dif.out_valid), 64'd1);
      check("stall_addr", 64'(dif.out_addr), 64'(prev_a));
      check("stall_data", 64'(dif.out_data), 64'(prev_d));
    end
    if (reset_n && dif.out_valid && dif.out_ready) got_q.push_back({dif.out_addr, dif.out_data});
    if (reset_n && done) done_cnt++;
    prev_stall = reset_n && dif.out_valid && !dif.out_ready;
    prev_a     = dif.out_addr;
    prev_d     = dif.out_data;
  end

  typedef struct {
    bit          start;
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
    bit          busy;
    bit          done;
  } vec_t;
  vec_t tbl[68];

  beat_t exp_q[$];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    dif.out_ready = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    dif2.out_ready = 1'b1;
`endif

    // Cycle table for a ready-high dump with extra start pulses at 5, 65, 66.
    for (int k = 0; k < 68; k++) begin
      int b;
      b = (k - 2) / 2;
      tbl[k].start = (k == 0) || (k == 5) || (k == 65) || (k == 66);
      tbl[k].v     = (k >= 2) && (k <= 64) && (k % 2 == 0);
      tbl[k].a     = 5'(b);
      tbl[k].d     = (b == 0) ? 32'h0 : 32'h1000_0000 + b;
      tbl[k].busy  = ((k >= 1) && (k <= 65)) || (k == 67);
      tbl[k].done  = (k == 65);
    end

    // Reset then idle.
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_valid", 64'(dif.out_valid), 64'd0);
      check("idle_done", 64'(done), 64'd0);
      check("idle_ra", 64'(ra), 64'd0);
      step();
    end

    // Table-driven full dump, start-while-busy, restart from IDLE.
    got_q.delete();
    done_cnt = 0;
    for (int k = 0; k < 68; k++) begin
      check("tbl_valid", 64'(dif.out_valid), 64'(tbl[k].v));
      if (tbl[k].v) begin
        check("tbl_addr", 64'(dif.out_addr), 64'(tbl[k].a));
        check("tbl_data", 64'(dif.out_data), 64'(tbl[k].d));
      end
      check("tbl_busy", 64'(busy), 64'(tbl[k].busy));
      check("tbl_done", 64'(done), 64'(tbl[k].done));
      start = tbl[k].start;
      step();
    end
    start = 1'b0;
    check("redump_first_valid", 64'(dif.out_valid), 64'd1);
    check("redump_first_addr", 64'(dif.out_addr), 64'd0);
    wait_done(200);
    step();
    check("two_dumps_beats", 64'(got_q.size()), 64'd64);
    check("two_dumps_done", 64'(done_cnt), 64'd2);

    // Backpressure on beat 0.
    got_q.delete();
    dif.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 2; k < 8; k++) begin
      check("bp_valid", 64'(dif.out_valid), 64'd1);
      check("bp_addr", 64'(dif.out_addr), 64'd0);
      check("bp_data", 64'(dif.out_data), 64'd0);
      step();
    end
    dif.out_ready = 1'b1;
    check("bp_release_valid", 64'(dif.out_valid), 64'd1);
    step();
    check("bp_fetch_gap", 64'(dif.out_valid), 64'd0);
    step();
    check("bp_beat1_valid", 64'(dif.out_valid), 64'd1);
    check("bp_beat1_addr", 64'(dif.out_addr), 64'd1);
    wait_done(200);
    step();
    check("bp_beats", 64'(got_q.size()), 64'd32);
    if (got_q.size() >= 2) begin
      check("bp_q0_addr", 64'(got_q[0].a), 64'd0);
      check("bp_q1_addr", 64'(got_q[1].a), 64'd1);
    end

    // Reset during SEND of beat 10.
    got_q.delete();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 22; k++) step();
    check("rst_pre_addr", 64'(dif.out_addr), 64'd10);
    check("rst_pre_valid", 64'(dif.out_valid), 64'd1);
    reset_n = 1'b0;
    step();
    check("rst_valid", 64'(dif.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    check("rst_beats_before", 64'(got_q.size()), 64'd10);
    for (int k = 0; k < 80; k++) step();
    check("rst_beats_after", 64'(got_q.size()), 64'd10);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_busy_after", 64'(busy), 64'd0);

    // Random contents, random backpressure, spurious starts while busy.
    for (int it = 0; it < 4; it++) begin
      logic [31:0] model_csum;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      exp_q.delete();
      model_csum = 32'h0;
      for (int a = 0; a < 32; a++) begin
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : mem[a];
        exp_q.push_back({5'(a), v});
        model_csum = {model_csum[30:0], model_csum[31]} ^ v;
      end
      got_q.delete();
      done_cnt = 0;
      start = 1'b1;
      step();
      begin
        bit seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
          dif.out_ready = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 7) == 0);
          step();
          if (done) begin
            seen = 1'b1;
            break;
          end
        end
        check("rand_timeout", 64'(seen), 64'd1);
      end
      start = 1'b0;
      dif.out_ready = 1'b1;
      step();
      check("rand_beats", 64'(got_q.size()), 64'd32);
      check("rand_done_cnt", 64'(done_cnt), 64'd1);
      check("rand_idle", 64'(busy), 64'd0);
      for (int i = 0; i < 32 && i < got_q.size(); i++) begin
        check("rand_addr", 64'(got_q[i].a), 64'(exp_q[i].a));
        check("rand_data", 64'(got_q[i].d), 64'(exp_q[i].d));
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      check("rand_csum", 64'(csum), 64'(model_csum));
      check("rand_csum_valid", 64'(csum_valid), 64'd1);
`endif
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Short-range dump x1..x3 through the second instance.
    mem[1] = 32'd1;
    mem[2] = 32'd2;
    mem[3] = 32'd4;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("cs_cleared_valid", 64'(csum_valid2), 64'd0);
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        step();
        if (done2) begin
          seen = 1'b1;
          break;
        end
      end
      check("cs_timeout", 64'(seen), 64'd1);
    end
    check("cs_valid_fin", 64'(csum_valid2), 64'd1);
    step();
    check("cs_value", 64'(csum2), 64'h4);
    check("cs_valid_idle", 64'(csum_valid2), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
